// File: rtl/pe_namespace_array.sv
// pe_namespace_array
//   Instruction buffer plus numNamespaces generic data namespaces, sitting
//   between the PE bus interface and the PE core.
//
//   Instruction buffer
//     inst_wrt/inst_in       push an instruction (dropped when full)
//     inst_fifo_full         buffer holds 2^instAddrLen entries
//     inst_flush             empty the buffer, reload mode from inst_loop_en
//     inst_loop_en           requested mode (1 = loop replay, 0 = stream)
//     inst_stall             suppress fetch this cycle
//     inst_out/inst_valid    registered fetch result (1-cycle latency)
//     inst_eol               fetched entry ends the pass (loop) or stream
//
//   Namespaces
//     bus_wrt_*              write port from the namespace bus (wins collisions)
//     core_wrt_*             write port from the PE core
//     core_wrt_conflict      core write lost to a bus write (1-cycle pulse)
//     rd_addr/rd_data        one registered write-first read port per namespace,
//                            namespace i packed at [i*width +: width]
//
//   clk, reset             single clock, synchronous active-high reset
module pe_namespace_array #(
  parameter int instLen          = 32,
  parameter int instAddrLen      = 6,
  parameter int dataLen          = 32,
  parameter int nsAddrLen        = 5,
  parameter int numNamespaces    = 4,
  parameter int logNumNamespaces = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               inst_wrt,
  input  logic [instLen-1:0]                 inst_in,
  output logic                               inst_fifo_full,
  input  logic                               inst_flush,
  input  logic                               inst_loop_en,
  input  logic                               inst_stall,
  output logic [instLen-1:0]                 inst_out,
  output logic                               inst_valid,
  output logic                               inst_eol,
  input  logic                               bus_wrt,
  input  logic [logNumNamespaces-1:0]        bus_wrt_ns,
  input  logic [nsAddrLen-1:0]               bus_wrt_addr,
  input  logic [dataLen-1:0]                 bus_wrt_data,
  input  logic                               core_wrt,
  input  logic [logNumNamespaces-1:0]        core_wrt_ns,
  input  logic [nsAddrLen-1:0]               core_wrt_addr,
  input  logic [dataLen-1:0]                 core_wrt_data,
  output logic                               core_wrt_conflict,
  input  logic [numNamespaces*nsAddrLen-1:0] rd_addr,
  output logic [numNamespaces*dataLen-1:0]   rd_data
);

  localparam int InstDepth = 1 << instAddrLen;
  localparam int NsDepth   = 1 << nsAddrLen;

  localparam logic [instAddrLen-1:0] PtrOne    = {{(instAddrLen-1){1'b0}}, 1'b1};
  localparam logic [instAddrLen:0]   CntOne    = {{instAddrLen{1'b0}}, 1'b1};
  localparam logic [instAddrLen:0]   FullCount = {1'b1, {instAddrLen{1'b0}}};

  // ---------------------------------------------------------------------------
  // Instruction buffer
  // ---------------------------------------------------------------------------
  logic [instLen-1:0]     inst_mem [InstDepth];

  logic [instAddrLen-1:0] head_q, head_d;
  logic [instAddrLen-1:0] wr_ptr_q, wr_ptr_d;
  logic [instAddrLen-1:0] rd_ptr_q, rd_ptr_d;
  logic [instAddrLen:0]   count_q, count_d;
  logic                   loop_q, loop_d;
  logic [instLen-1:0]     inst_out_q, inst_out_d;
  logic                   inst_valid_q, inst_valid_d;
  logic                   inst_eol_q, inst_eol_d;

  logic                   buf_full;
  logic                   do_push;
  logic                   do_fetch;
  logic                   loop_eff;
  logic                   stream_pop;

  assign buf_full = (count_q == FullCount);
  assign do_push  = inst_wrt && !buf_full;
  assign do_fetch = !inst_stall && (count_q != '0);

  // The mode register only follows inst_loop_en between passes (read pointer
  // back at head). The value being loaded already governs this cycle's fetch,
  // so the first pass after a switch is handled in the new mode.
  assign loop_eff   = (rd_ptr_q == head_q) ? inst_loop_en : loop_q;
  assign stream_pop = do_fetch && !loop_eff;

  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned; a missing default would infer a latch.
    head_d       = head_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    loop_d       = loop_eff;
    inst_out_d   = inst_out_q;
    inst_valid_d = 1'b0;
    inst_eol_d   = 1'b0;

    if (inst_flush) begin
      head_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      loop_d   = inst_loop_en;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end

      if (do_fetch) begin
        inst_out_d   = inst_mem[rd_ptr_q];
        inst_valid_d = 1'b1;
        if (loop_eff) begin
          // Last stored entry of the pass: wrap back to the oldest entry.
          // wr_ptr is compared before any same-cycle push, so a new entry
          // joins the loop body on the next pass.
          if (rd_ptr_q + PtrOne == wr_ptr_q) begin
            inst_eol_d = 1'b1;
            rd_ptr_d   = head_q;
          end else begin
            rd_ptr_d = rd_ptr_q + PtrOne;
          end
        end else begin
          rd_ptr_d   = rd_ptr_q + PtrOne;
          head_d     = head_q + PtrOne;
          inst_eol_d = (count_q == CntOne) && !do_push;
        end
      end

      case ({do_push, stream_pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: storage arrays have no reset; only pointers, count and outputs do,
  // which keeps the arrays mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push && !inst_flush) begin
      inst_mem[wr_ptr_q] <= inst_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Namespaces
  // ---------------------------------------------------------------------------
  logic [dataLen-1:0]               ns_mem [numNamespaces][NsDepth];

  logic [numNamespaces-1:0]         bus_hit;
  logic [numNamespaces-1:0]         core_hit;
  logic                             conflict_q, conflict_d;
  logic [numNamespaces*dataLen-1:0] rd_data_q, rd_data_d;

  always_comb begin
    bus_hit  = '0;
    core_hit = '0;
    for (int n = 0; n < numNamespaces; n++) begin
      bus_hit[n]  = bus_wrt && (int'(bus_wrt_ns) == n);
      // A bus write to the same namespace takes the single write slot.
      core_hit[n] = core_wrt && (int'(core_wrt_ns) == n) && !bus_hit[n];
    end
  end

  // Out-of-range namespace indices never match a bus_hit, so they raise no
  // conflict either.
  assign conflict_d = core_wrt && bus_wrt && (core_wrt_ns == bus_wrt_ns) &&
                      (int'(core_wrt_ns) < numNamespaces);

  always_comb begin
    rd_data_d = '0;
    for (int n = 0; n < numNamespaces; n++) begin
      // Write-first: a write landing on the address being read is forwarded.
      if (bus_hit[n] && bus_wrt_addr == rd_addr[n*nsAddrLen +: nsAddrLen]) begin
        rd_data_d[n*dataLen +: dataLen] = bus_wrt_data;
      end else if (core_hit[n] && core_wrt_addr == rd_addr[n*nsAddrLen +: nsAddrLen]) begin
        rd_data_d[n*dataLen +: dataLen] = core_wrt_data;
      end else begin
        rd_data_d[n*dataLen +: dataLen] = ns_mem[n][rd_addr[n*nsAddrLen +: nsAddrLen]];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < numNamespaces; n++) begin
      if (bus_hit[n]) begin
        ns_mem[n][bus_wrt_addr] <= bus_wrt_data;
      end else if (core_hit[n]) begin
        ns_mem[n][core_wrt_addr] <= core_wrt_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      loop_q       <= 1'b0;
      inst_out_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_eol_q   <= 1'b0;
      conflict_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      head_q       <= head_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      loop_q       <= loop_d;
      inst_out_q   <= inst_out_d;
      inst_valid_q <= inst_valid_d;
      inst_eol_q   <= inst_eol_d;
      conflict_q   <= conflict_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign inst_fifo_full    = buf_full;
  assign inst_out          = inst_out_q;
  assign inst_valid        = inst_valid_q;
  assign inst_eol          = inst_eol_q;
  assign core_wrt_conflict = conflict_q;
  assign rd_data           = rd_data_q;

endmodule

// File: tb/tb_pe_namespace_array.sv
// Testbench for pe_namespace_array: directed scenarios plus a randomized run,
// checked against a queue-based model of the instruction buffer and an
// array model of the namespaces. Three namespaces with a 2-bit select so the
// out-of-range index (3) can be exercised.
module tb_pe_namespace_array;

  localparam int IL    = 32;
  localparam int IAL   = 6;
  localparam int DL    = 32;
  localparam int NAL   = 5;
  localparam int NN    = 3;
  localparam int LNN   = 2;
  localparam int DEPTH = 1 << IAL;

  logic              clk = 1'b0;
  logic              reset;
  logic              inst_wrt;
  logic [IL-1:0]     inst_in;
  logic              inst_fifo_full;
  logic              inst_flush;
  logic              inst_loop_en;
  logic              inst_stall;
  logic [IL-1:0]     inst_out;
  logic              inst_valid;
  logic              inst_eol;
  logic              bus_wrt;
  logic [LNN-1:0]    bus_wrt_ns;
  logic [NAL-1:0]    bus_wrt_addr;
  logic [DL-1:0]     bus_wrt_data;
  logic              core_wrt;
  logic [LNN-1:0]    core_wrt_ns;
  logic [NAL-1:0]    core_wrt_addr;
  logic [DL-1:0]     core_wrt_data;
  logic              core_wrt_conflict;
  logic [NN*NAL-1:0] rd_addr;
  logic [NN*DL-1:0]  rd_data;

  int n_checks = 0;
  int n_pass   = 0;

  pe_namespace_array #(
    .instLen(IL), .instAddrLen(IAL), .dataLen(DL), .nsAddrLen(NAL),
    .numNamespaces(NN), .logNumNamespaces(LNN)
  ) dut (
    .clk(clk), .reset(reset),
    .inst_wrt(inst_wrt), .inst_in(inst_in), .inst_fifo_full(inst_fifo_full),
    .inst_flush(inst_flush), .inst_loop_en(inst_loop_en), .inst_stall(inst_stall),
    .inst_out(inst_out), .inst_valid(inst_valid), .inst_eol(inst_eol),
    .bus_wrt(bus_wrt), .bus_wrt_ns(bus_wrt_ns), .bus_wrt_addr(bus_wrt_addr),
    .bus_wrt_data(bus_wrt_data),
    .core_wrt(core_wrt), .core_wrt_ns(core_wrt_ns), .core_wrt_addr(core_wrt_addr),
    .core_wrt_data(core_wrt_data), .core_wrt_conflict(core_wrt_conflict),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [IL-1:0] m_q[$];        // stored program, oldest first
  int            m_pos;         // loop-mode replay position within m_q
  bit            m_loop;
  logic [IL-1:0] m_out;
  bit            m_valid, m_eol, m_conf;
  logic [DL-1:0] m_mem   [NN][1 << NAL];
  bit            m_known [NN][1 << NAL];
  logic [DL-1:0] m_rd    [NN];
  bit            m_rd_known [NN];

  function automatic void model_step();
    int  sz;
    bit  eff_loop, push_ok, fetch;
    if (reset) begin
      m_q.delete();
      m_pos = 0; m_loop = 0; m_out = '0; m_valid = 0; m_eol = 0; m_conf = 0;
      for (int n = 0; n < NN; n++) begin
        m_rd[n] = '0;
        m_rd_known[n] = 1;
      end
      return;
    end
    sz       = m_q.size();
    eff_loop = (m_pos == 0) ? inst_loop_en : m_loop;
    m_valid  = 0;
    m_eol    = 0;
    if (inst_flush) begin
      m_q.delete();
      m_pos  = 0;
      m_loop = inst_loop_en;
    end else begin
      push_ok = inst_wrt && (sz < DEPTH);
      fetch   = !inst_stall && (sz != 0);
      if (fetch) begin
        m_valid = 1;
        if (eff_loop) begin
          m_out = m_q[m_pos];
          m_eol = (m_pos == sz - 1);
          m_pos = m_eol ? 0 : m_pos + 1;
        end else begin
          m_out = m_q.pop_front();
          m_eol = (sz == 1) && !push_ok;
        end
      end
      if (push_ok) m_q.push_back(inst_in);
      m_loop = eff_loop;
    end
    m_conf = bus_wrt && core_wrt && (bus_wrt_ns == core_wrt_ns) && (int'(bus_wrt_ns) < NN);
    if (bus_wrt && int'(bus_wrt_ns) < NN) begin
      m_mem[int'(bus_wrt_ns)][bus_wrt_addr]   = bus_wrt_data;
      m_known[int'(bus_wrt_ns)][bus_wrt_addr] = 1;
    end
    if (core_wrt && int'(core_wrt_ns) < NN && !(bus_wrt && bus_wrt_ns == core_wrt_ns)) begin
      m_mem[int'(core_wrt_ns)][core_wrt_addr]   = core_wrt_data;
      m_known[int'(core_wrt_ns)][core_wrt_addr] = 1;
    end
    for (int n = 0; n < NN; n++) begin
      m_rd[n]       = m_mem[n][rd_addr[n*NAL +: NAL]];
      m_rd_known[n] = m_known[n][rd_addr[n*NAL +: NAL]];
    end
  endfunction

  // One clock edge: the model consumes the same inputs the DUT sampled, and
  // outputs are inspected 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    inst_wrt = 0; inst_in = '0; inst_flush = 0; inst_stall = 1;
    bus_wrt = 0; bus_wrt_ns = '0; bus_wrt_addr = '0; bus_wrt_data = '0;
    core_wrt = 0; core_wrt_ns = '0; core_wrt_addr = '0; core_wrt_data = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1; inst_loop_en = 0; rd_addr = '0;
    idle_inputs();
    tick();
    tick();
    n_checks++;
    if (inst_out !== '0 || inst_valid !== 1'b0 || inst_eol !== 1'b0 ||
        inst_fifo_full !== 1'b0 || core_wrt_conflict !== 1'b0 || rd_data !== '0) begin
      $display("FAIL reset_state: out=%0h v=%0b e=%0b full=%0b conf=%0b rd=%0h, want all zero",
               inst_out, inst_valid, inst_eol, inst_fifo_full, core_wrt_conflict, rd_data);
    end else n_pass++;
    reset = 0;
  endtask

  task automatic test_stream();
    logic [IL-1:0] vals [3];
    bit            ev, ee;
    logic [IL-1:0] eo;
    vals[0] = 32'd3; vals[1] = 32'd5; vals[2] = 32'd7;
    inst_stall = 1;
    for (int i = 0; i < 3; i++) begin
      inst_wrt = 1; inst_in = vals[i];
      tick();
    end
    inst_wrt = 0;
    n_checks++;
    if (inst_valid !== 1'b0) begin
      $display("FAIL stream_stalled: valid=%0b, want 0", inst_valid);
    end else n_pass++;
    inst_stall = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ev = (i < 3);
      ee = (i == 2);
      eo = vals[(i < 3) ? i : 2];
      n_checks++;
      if (inst_valid !== ev || inst_eol !== ee || inst_out !== eo) begin
        $display("FAIL stream_fetch[%0d]: v=%0b e=%0b out=%0h, want v=%0b e=%0b out=%0h",
                 i, inst_valid, inst_eol, inst_out, ev, ee, eo);
      end else n_pass++;
    end
  endtask

  task automatic test_full();
    bit saw_ff = 0;
    inst_stall = 1;
    for (int i = 0; i < DEPTH; i++) begin
      inst_wrt = 1; inst_in = IL'(i);
      tick();
    end
    n_checks++;
    if (inst_fifo_full !== 1'b1) begin
      $display("FAIL full_after_64: full=%0b, want 1", inst_fifo_full);
    end else n_pass++;
    inst_in = 32'hFF;
    tick();
    inst_wrt = 0;
    n_checks++;
    if (inst_fifo_full !== 1'b1) begin
      $display("FAIL full_after_drop: full=%0b, want 1", inst_fifo_full);
    end else n_pass++;
    inst_stall = 0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      if (inst_out === 32'hFF) saw_ff = 1;
      n_checks++;
      if (inst_valid !== 1'b1 || inst_out !== IL'(i) || inst_eol !== (i == DEPTH - 1)) begin
        $display("FAIL full_drain[%0d]: v=%0b e=%0b out=%0h, want v=1 e=%0b out=%0h",
                 i, inst_valid, inst_eol, inst_out, (i == DEPTH - 1), i);
      end else n_pass++;
    end
    tick();
    n_checks++;
    if (inst_valid !== 1'b0 || inst_fifo_full !== 1'b0 || saw_ff) begin
      $display("FAIL full_empty: v=%0b full=%0b saw_ff=%0b, want 0 0 0",
               inst_valid, inst_fifo_full, saw_ff);
    end else n_pass++;
  endtask

  task automatic test_loop();
    logic [IL-1:0] eo;
    inst_stall = 1; inst_loop_en = 1; inst_flush = 1;
    tick();
    inst_flush = 0;
    for (int i = 1; i <= 3; i++) begin
      inst_wrt = 1; inst_in = IL'(i);
      tick();
    end
    inst_wrt = 0; inst_stall = 0;
    for (int k = 0; k < 9; k++) begin
      tick();
      eo = IL'((k % 3) + 1);
      n_checks++;
      if (inst_valid !== 1'b1 || inst_out !== eo || inst_eol !== (k % 3 == 2)) begin
        $display("FAIL loop_replay[%0d]: v=%0b e=%0b out=%0h, want v=1 e=%0b out=%0h",
                 k, inst_valid, inst_eol, inst_out, (k % 3 == 2), eo);
      end else n_pass++;
    end
    // Flush wins over the fetch requested in the same cycle.
    inst_flush = 1;
    tick();
    inst_flush = 0;
    n_checks++;
    if (inst_valid !== 1'b0 || inst_eol !== 1'b0) begin
      $display("FAIL loop_flush: v=%0b e=%0b, want 0 0", inst_valid, inst_eol);
    end else n_pass++;
    tick();
    n_checks++;
    if (inst_valid !== 1'b0) begin
      $display("FAIL loop_flush_empty: v=%0b, want 0", inst_valid);
    end else n_pass++;
  endtask

  task automatic test_mode_switch();
    logic [IL-1:0] outs [5];
    bit            eols [5];
    outs[0] = 2; outs[1] = 3; outs[2] = 1; outs[3] = 2; outs[4] = 3;
    eols[0] = 0; eols[1] = 1; eols[2] = 0; eols[3] = 0; eols[4] = 1;
    inst_stall = 1; inst_loop_en = 1; inst_flush = 1;
    tick();
    inst_flush = 0;
    for (int i = 1; i <= 3; i++) begin
      inst_wrt = 1; inst_in = IL'(i);
      tick();
    end
    inst_wrt = 0; inst_stall = 0;
    tick();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_out !== 32'd1 || inst_eol !== 1'b0) begin
      $display("FAIL switch_first: v=%0b e=%0b out=%0h, want v=1 e=0 out=1",
               inst_valid, inst_eol, inst_out);
    end else n_pass++;
    inst_loop_en = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (inst_valid !== 1'b1 || inst_out !== outs[k] || inst_eol !== eols[k]) begin
        $display("FAIL switch_seq[%0d]: v=%0b e=%0b out=%0h, want v=1 e=%0b out=%0h",
                 k, inst_valid, inst_eol, inst_out, eols[k], outs[k]);
      end else n_pass++;
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (inst_valid !== 1'b0) begin
        $display("FAIL switch_drained[%0d]: v=%0b, want 0", k, inst_valid);
      end else n_pass++;
    end
  endtask

  task automatic test_namespaces();
    // Seed known contents.
    bus_wrt = 1; bus_wrt_ns = 2'd1; bus_wrt_addr = 5'd6; bus_wrt_data = 32'h66;
    tick();
    for (int n = 0; n < NN; n++) begin
      bus_wrt_ns = LNN'(n); bus_wrt_addr = 5'd7; bus_wrt_data = 32'h700 + DL'(n);
      tick();
    end
    // Same-namespace collision: bus wins.
    bus_wrt = 1; bus_wrt_ns = 2'd1; bus_wrt_addr = 5'd4; bus_wrt_data = 32'd10;
    core_wrt = 1; core_wrt_ns = 2'd1; core_wrt_addr = 5'd6; core_wrt_data = 32'd20;
    tick();
    bus_wrt = 0; core_wrt = 0;
    n_checks++;
    if (core_wrt_conflict !== 1'b1) begin
      $display("FAIL ns_conflict: conf=%0b, want 1", core_wrt_conflict);
    end else n_pass++;
    rd_addr[1*NAL +: NAL] = 5'd4;
    tick();
    n_checks++;
    if (core_wrt_conflict !== 1'b0 || rd_data[1*DL +: DL] !== 32'd10) begin
      $display("FAIL ns_conflict_read4: conf=%0b rd=%0h, want conf=0 rd=a",
               core_wrt_conflict, rd_data[1*DL +: DL]);
    end else n_pass++;
    rd_addr[1*NAL +: NAL] = 5'd6;
    tick();
    n_checks++;
    if (rd_data[1*DL +: DL] !== 32'h66) begin
      $display("FAIL ns_conflict_read6: rd=%0h, want 66", rd_data[1*DL +: DL]);
    end else n_pass++;
    // Different namespaces: both land.
    bus_wrt = 1; bus_wrt_ns = 2'd1; bus_wrt_addr = 5'd4; bus_wrt_data = 32'h11;
    core_wrt = 1; core_wrt_ns = 2'd2; core_wrt_addr = 5'd6; core_wrt_data = 32'd20;
    tick();
    bus_wrt = 0; core_wrt = 0;
    n_checks++;
    if (core_wrt_conflict !== 1'b0) begin
      $display("FAIL ns_no_conflict: conf=%0b, want 0", core_wrt_conflict);
    end else n_pass++;
    rd_addr[1*NAL +: NAL] = 5'd4; rd_addr[2*NAL +: NAL] = 5'd6;
    tick();
    n_checks++;
    if (rd_data[1*DL +: DL] !== 32'h11 || rd_data[2*DL +: DL] !== 32'd20) begin
      $display("FAIL ns_both_written: ns1=%0h ns2=%0h, want 11 14",
               rd_data[1*DL +: DL], rd_data[2*DL +: DL]);
    end else n_pass++;
    // Out-of-range namespace on both ports: ignored, no conflict.
    bus_wrt = 1; bus_wrt_ns = 2'd3; bus_wrt_addr = 5'd7; bus_wrt_data = 32'hDEAD;
    core_wrt = 1; core_wrt_ns = 2'd3; core_wrt_addr = 5'd7; core_wrt_data = 32'hBEEF;
    for (int n = 0; n < NN; n++) rd_addr[n*NAL +: NAL] = 5'd7;
    tick();
    bus_wrt = 0; core_wrt = 0;
    tick();
    n_checks++;
    if (core_wrt_conflict !== 1'b0) begin
      $display("FAIL ns_oob_conflict: conf=%0b, want 0", core_wrt_conflict);
    end else n_pass++;
    for (int n = 0; n < NN; n++) begin
      n_checks++;
      if (rd_data[n*DL +: DL] !== 32'h700 + DL'(n)) begin
        $display("FAIL ns_oob_untouched[%0d]: rd=%0h, want %0h",
                 n, rd_data[n*DL +: DL], 32'h700 + n);
      end else n_pass++;
    end
  endtask

  task automatic test_bypass_reset();
    rd_addr[0 +: NAL] = 5'd4;
    bus_wrt = 1; bus_wrt_ns = 2'd0; bus_wrt_addr = 5'd4; bus_wrt_data = 32'hABCD;
    tick();
    bus_wrt = 0;
    n_checks++;
    if (rd_data[0 +: DL] !== 32'hABCD) begin
      $display("FAIL bypass: rd=%0h, want abcd", rd_data[0 +: DL]);
    end else n_pass++;
    inst_loop_en = 0; inst_stall = 1;
    for (int i = 0; i < 3; i++) begin
      inst_wrt = 1; inst_in = 32'h40 + IL'(i);
      tick();
    end
    inst_wrt = 0; inst_stall = 0;
    tick();                       // one fetched, two still queued
    reset = 1;
    tick();
    n_checks++;
    if (inst_valid !== 1'b0 || inst_fifo_full !== 1'b0 || inst_out !== '0) begin
      $display("FAIL reset_mid: v=%0b full=%0b out=%0h, want 0 0 0",
               inst_valid, inst_fifo_full, inst_out);
    end else n_pass++;
    reset = 0;
    tick();
    n_checks++;
    if (inst_valid !== 1'b0 || rd_data[0 +: DL] !== 32'hABCD) begin
      $display("FAIL reset_retain: v=%0b rd=%0h, want v=0 rd=abcd",
               inst_valid, rd_data[0 +: DL]);
    end else n_pass++;
  endtask

  task automatic test_random();
    inst_stall = 1; inst_flush = 1; inst_loop_en = 0;
    tick();
    inst_flush = 0;
    for (int c = 0; c < 800; c++) begin
      reset        = ($urandom_range(0, 199) == 0);
      inst_wrt     = ($urandom_range(0, 99) < 60);
      inst_in      = $urandom;
      inst_stall   = ($urandom_range(0, 99) < 35);
      inst_flush   = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 4) inst_loop_en = ~inst_loop_en;
      bus_wrt      = !reset && ($urandom_range(0, 99) < 40);
      bus_wrt_ns   = LNN'($urandom_range(0, 3));
      bus_wrt_addr = NAL'($urandom_range(0, 7));
      bus_wrt_data = $urandom;
      core_wrt     = !reset && ($urandom_range(0, 99) < 40);
      core_wrt_ns  = LNN'($urandom_range(0, 3));
      core_wrt_addr = NAL'($urandom_range(0, 7));
      core_wrt_data = $urandom;
      for (int n = 0; n < NN; n++) rd_addr[n*NAL +: NAL] = NAL'($urandom_range(0, 7));
      tick();
      n_checks++;
      if (inst_valid !== m_valid || inst_eol !== m_eol || inst_out !== m_out ||
          inst_fifo_full !== (m_q.size() == DEPTH)) begin
        $display("FAIL rand_inst[%0d]: v=%0b e=%0b out=%0h full=%0b, want v=%0b e=%0b out=%0h full=%0b",
                 c, inst_valid, inst_eol, inst_out, inst_fifo_full,
                 m_valid, m_eol, m_out, (m_q.size() == DEPTH));
      end else n_pass++;
      n_checks++;
      if (core_wrt_conflict !== m_conf) begin
        $display("FAIL rand_conflict[%0d]: conf=%0b, want %0b", c, core_wrt_conflict, m_conf);
      end else n_pass++;
      for (int n = 0; n < NN; n++) begin
        if (m_rd_known[n]) begin
          n_checks++;
          if (rd_data[n*DL +: DL] !== m_rd[n]) begin
            $display("FAIL rand_rd[%0d] ns%0d: rd=%0h, want %0h", c, n, rd_data[n*DL +: DL], m_rd[n]);
          end else n_pass++;
        end
      end
    end
    reset = 0;
  endtask

  initial begin
    for (int n = 0; n < NN; n++) begin
      for (int a = 0; a < (1 << NAL); a++) begin
        m_mem[n][a]   = '0;
        m_known[n][a] = 0;
      end
    end
    test_reset();
    test_stream();
    test_full();
    test_loop();
    test_mode_switch();
    test_namespaces();
    test_bypass_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
